// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = LSU side, master = execute stage plus data memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr,
           mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr,
           mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word-only data memory; SB/SH use read-modify-write.
// Define LSU_RANGE_CHECK_EN to flag accesses beyond MEM_BYTES as errors.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StStore, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [31:0] r_data, w_data_next;
  logic        r_err, w_err_next;
  logic        w_accept;

  logic        w_req_illegal, w_req_misalign, w_req_range, w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val, w_merged, w_mem_addr;

  always_comb begin
    w_req_illegal = 1'b0;
    if (bus.req_we) begin
      w_req_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    w_req_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

`ifdef LSU_RANGE_CHECK_EN
  assign w_req_range = {bus.req_addr[31:2], 2'b00} > (MEM_BYTES - 32'd4);
`else
  assign w_req_range = 1'b0;
`endif

  assign w_req_err  = w_req_illegal || w_req_misalign || w_req_range;
  assign w_mem_addr = {r_addr[31:2], 2'b00};

  // Little-endian lane select from the word returned by memory
  assign w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_err_next     = r_err;
    w_accept       = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_err   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_err_next  = w_req_err;
          w_data_next = 32'h0;
          if (w_req_err) begin
            w_state_next = StResp;
          end else if (!bus.req_we) begin
            w_state_next = StLoad;
          end else if (bus.req_funct3 == 3'b010) begin
            w_state_next = StStore;
            w_data_next  = bus.req_wdata;
          end else begin
            w_state_next = StRmwRd;
          end
        end
      end
      StLoad: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = w_mem_addr;
        w_data_next  = w_load_val;
        w_state_next = StResp;
      end
      StRmwRd: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = w_mem_addr;
        w_data_next  = w_merged;
        w_state_next = StStore;
      end
      StStore: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = w_mem_addr;
        bus.mem_wdata = r_data;
        // Stores report zero read data
        w_data_next   = 32'h0;
        w_state_next  = StResp;
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_data;
        bus.resp_err   = r_err;
        if (bus.resp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 16'h0;
      r_data   <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata[15:0];
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected responses plus a
// word-addressed memory model and a strobe monitor.
module tb_load_store_unit;
  logic clk;
  logic rst;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(1024)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem [256];
  int          rd_cnt = 0, wr_cnt = 0, overlap = 0, idle_bus = 0;
  logic [31:0] last_raddr = 32'h0, last_wdata = 32'h0;

  logic [31:0] obs_rd, obs_wd;
  logic        obs_err;
  int          obs_lat, obs_nrd, obs_nwr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_read) begin
        rd_cnt     <= rd_cnt + 1;
        last_raddr <= bus.mem_addr;
      end
      if (bus.mem_write) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_write) overlap <= overlap + 1;
      if ((!bus.mem_read && !bus.mem_write && (bus.mem_addr != 0 || bus.mem_wdata != 0)) ||
          ((bus.req_ready || bus.resp_valid) && (bus.mem_read || bus.mem_write)))
        idle_bus <= idle_bus + 1;
    end
  end

  // Issues one request, waits (bounded) for its response, then completes the handshake.
  task automatic run_vec(input vec_t v);
    int rd0, wr0;
    sb.push_back(v.e);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    obs_lat = 0;
    @(posedge clk); #1;
    obs_lat = 1;
    bus.req_valid = 1'b0;
    while (!bus.resp_valid && obs_lat < 20) begin
      @(posedge clk); #1;
      obs_lat++;
    end
    if (!bus.resp_valid) obs_lat = 99;
    obs_rd  = bus.resp_rdata;
    obs_err = bus.resp_err;
    obs_nrd = rd_cnt - rd0;
    obs_nwr = wr_cnt - wr0;
    obs_wd  = last_wdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got valid=%b err=%b rdata=%h, want 0 0 0",
               bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    n_checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got rd=%b wr=%b addr=%h wdata=%h, want all 0",
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got req_ready=%b, want 1", bus.req_ready);
    end
  endtask

  task automatic check_tbl(input string name, input vec_t tbl[$]);
    exp_t e;
    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_rd !== e.rdata || obs_err !== e.err || obs_lat != e.lat) begin
        n_fail++;
        $display("FAIL %s[%0d] resp: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                 name, i, obs_rd, obs_err, obs_lat, e.rdata, e.err, e.lat);
      end
      n_checks++;
      if (obs_nrd != e.nrd || obs_nwr != e.nwr || (e.nwr != 0 && obs_wd !== e.wdata)) begin
        n_fail++;
        $display("FAIL %s[%0d] mem: got reads=%0d writes=%0d wdata=%h, want %0d %0d %h",
                 name, i, obs_nrd, obs_nwr, obs_wd, e.nrd, e.nwr, e.wdata);
      end
    end
  endtask

  task automatic test_word();
    vec_t t[$];
    t.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, '{32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF}});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0, '{32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0}});
    check_tbl("word", t);
  endtask

  task automatic test_subword_load();
    vec_t t[$];
    t.push_back('{1'b0, 3'b000, 32'h13, 32'h0, '{32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b100, 32'h13, 32'h0, '{32'h000000DE, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b001, 32'h10, 32'h0, '{32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b101, 32'h12, 32'h0, '{32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b000, 32'h10, 32'h0, '{32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b100, 32'h11, 32'h0, '{32'h000000BE, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b001, 32'h12, 32'h0, '{32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0}});
    check_tbl("subload", t);
  endtask

  task automatic test_subword_store();
    vec_t t[$];
    t.push_back('{1'b1, 3'b000, 32'h11, 32'h00000055, '{32'h0, 1'b0, 3, 1, 1, 32'hDEAD55EF}});
    t.push_back('{1'b1, 3'b001, 32'h12, 32'h00001234, '{32'h0, 1'b0, 3, 1, 1, 32'h123455EF}});
    t.push_back('{1'b1, 3'b000, 32'h10, 32'hAABBCCFF, '{32'h0, 1'b0, 3, 1, 1, 32'h123455FF}});
    t.push_back('{1'b1, 3'b000, 32'h13, 32'h00000080, '{32'h0, 1'b0, 3, 1, 1, 32'h803455FF}});
    t.push_back('{1'b0, 3'b010, 32'h10, 32'h0, '{32'h803455FF, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b000, 32'h13, 32'h0, '{32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0}});
    t.push_back('{1'b0, 3'b101, 32'h10, 32'h0, '{32'h000055FF, 1'b0, 2, 1, 0, 32'h0}});
    check_tbl("substore", t);
  endtask

  task automatic test_errors();
    vec_t t[$];
    t.push_back('{1'b0, 3'b010, 32'h12, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b1, 3'b001, 32'h11, 32'h1234, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b001, 32'h11, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b101, 32'h13, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b011, 32'h10, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b110, 32'h10, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b111, 32'h10, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b1, 3'b100, 32'h10, 32'h77, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b1, 3'b011, 32'h10, 32'h77, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b1, 3'b010, 32'h16, 32'h77, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    check_tbl("err", t);
  endtask

  task automatic test_stall();
    exp_t e;
    int   n;
    sb.push_back('{32'h803455FF, 1'b0, 2, 1, 0, 32'h0});
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || n != e.lat) begin
      n_fail++;
      $display("FAIL stall_first: got valid=%b rdata=%h lat=%0d, want 1 %h %0d",
               bus.resp_valid, bus.resp_rdata, n, e.rdata, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || bus.resp_err !== 1'b0 ||
          bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 %h 0 0",
                 c, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, e.rdata);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b ready=%b, want 0 1",
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_range();
    vec_t t[$];
    t.push_back('{1'b1, 3'b010, 32'h0, 32'hCAFEF00D, '{32'h0, 1'b0, 2, 0, 1, 32'hCAFEF00D}});
`ifdef LSU_RANGE_CHECK_EN
    t.push_back('{1'b0, 3'b010, 32'h400, 32'h0, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b1, 3'b010, 32'h400, 32'h5, '{32'h0, 1'b1, 1, 0, 0, 32'h0}});
    t.push_back('{1'b0, 3'b010, 32'h3FC, 32'h0, '{32'h0, 1'b0, 2, 1, 0, 32'h0}});
    check_tbl("range", t);
`else
    // Model memory decodes addr[9:2], so 0x400 aliases word 0
    t.push_back('{1'b0, 3'b010, 32'h400, 32'h0, '{32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0}});
    check_tbl("range", t);
    n_checks++;
    if (last_raddr !== 32'h400) begin
      n_fail++;
      $display("FAIL range_addr: got mem_addr=%h, want 00000400", last_raddr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int wr0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h11111111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_store: got mem_write=%b, want 1", bus.mem_write);
    end
    wr0 = wr_cnt;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_now: got wr=%b ready=%b valid=%b, want 0 1 0",
               bus.mem_write, bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_cnt != wr0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got writes=%0d ready=%b valid=%b, want 0 1 0",
               wr_cnt - wr0, bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL overlap: got %0d cycles with read and write, want 0", overlap);
    end
    n_checks++;
    if (idle_bus != 0) begin
      n_fail++;
      $display("FAIL idle_bus: got %0d cycles with stray mem outputs, want 0", idle_bus);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_stall();
    test_range();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
